button_event_detect: RTL and testbench



---
 rtl/odsmr_btn_pkg.sv | 28 ++
 rtl/btn_debounce.sv | 54 +++++
 rtl/button_event_detect.sv | 153 +++++++++++++++
 tb/tb_button_event_detect.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/odsmr_btn_pkg.sv
// Shared definitions for the front-panel button event block:
// power FSM state encoding, Interrupt bit positions and edge helpers.
package odsmr_btn_pkg;

  // Power button FSM states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    LONG    = 2'd2
  } pwr_state_e;

  // Bit positions on the Interrupt bus.
  localparam int INT_RST_REL = 0;  // reset button released (ATX)
  localparam int INT_RST_PRS = 1;  // reset button pressed (non-ATX)
  localparam int INT_PWR_REL = 2;  // power button short release (ATX)
  localparam int INT_PWR_PRS = 3;  // power button pressed (non-ATX)

  // Rising edge of a level given its value one cycle earlier.
  function automatic logic edge_rise(input logic cur, input logic prev);
    return cur & ~prev;
  endfunction

  // Falling edge of a level given its value one cycle earlier.
  function automatic logic edge_fall(input logic cur, input logic prev);
    return ~cur & prev;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Synchroniser plus debounce counter for one raw active-low button.
// db_o is 1 while the button is accepted as pressed. A new level is
// accepted only after it has been seen for DEBOUNCE_CNT consecutive
// cycles at the synchroniser output; any bounce back restarts the count.
module btn_debounce
  import odsmr_btn_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CNT = 655,
  parameter int DB_W         = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n_i,
  output logic db_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [DB_W-1:0]        cnt_q, cnt_d;
  logic                   db_q, db_d;
  logic                   sync_pressed;

  // Shift the raw pin into the chain and run the stability counter.
  always_comb begin
    sync_d       = {sync_q[SYNC_STAGES-2:0], btn_n_i};
    sync_pressed = ~sync_q[SYNC_STAGES-1];
    cnt_d        = '0;
    db_d         = db_q;
    if (sync_pressed != db_q) begin
      if (cnt_q == DB_W'(DEBOUNCE_CNT - 1)) begin
        db_d  = ~db_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Chain resets to all-ones (released); counter and level to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
      cnt_q  <= '0;
      db_q   <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      db_q   <= db_d;
    end
  end

  assign db_o = db_q;

endmodule

// File: rtl/button_event_detect.sv
// Front-panel power/reset button event detector.
// Debounces both buttons and turns level changes into single-cycle
// Interrupt pulses. With BUTTON_LONG_PRESS_EN defined, a power press
// held long enough enters LONG, raises ForceOff until release and
// suppresses the release pulse; without it ForceOff is tied low and
// every power release pulses Interrupt[2].
module button_event_detect
  import odsmr_btn_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int DEBOUNCE_CNT   = 655,
  parameter int DB_W           = 10,
  parameter int LONG_PRESS_CNT = 131072,
  parameter int LP_W           = 18
) (
  input  logic       CLK32768,
  input  logic       Reset,
  input  logic       PwrBtnN,
  input  logic       RstBtnN,
  output logic [3:0] Interrupt,
  output logic       PwrBtnDb,
  output logic       RstBtnDb,
  output logic       ForceOff
);

  logic       pwr_db, rst_db;
  logic       pwr_db_prev_q, rst_db_prev_q;
  logic       pwr_rise, pwr_fall, rst_rise, rst_fall;
  logic [3:0] int_q, int_d;
  pwr_state_e pwr_state_q, pwr_state_d;
  logic       force_off_q, force_off_d;

  btn_debounce #(
    .SYNC_STAGES (SYNC_STAGES),
    .DEBOUNCE_CNT(DEBOUNCE_CNT),
    .DB_W        (DB_W)
  ) u_pwr_db (
    .clk    (CLK32768),
    .rst    (Reset),
    .btn_n_i(PwrBtnN),
    .db_o   (pwr_db)
  );

  btn_debounce #(
    .SYNC_STAGES (SYNC_STAGES),
    .DEBOUNCE_CNT(DEBOUNCE_CNT),
    .DB_W        (DB_W)
  ) u_rst_db (
    .clk    (CLK32768),
    .rst    (Reset),
    .btn_n_i(RstBtnN),
    .db_o   (rst_db)
  );

  assign pwr_rise = edge_rise(pwr_db, pwr_db_prev_q);
  assign pwr_fall = edge_fall(pwr_db, pwr_db_prev_q);
  assign rst_rise = edge_rise(rst_db, rst_db_prev_q);
  assign rst_fall = edge_fall(rst_db, rst_db_prev_q);

`ifdef BUTTON_LONG_PRESS_EN
  logic [LP_W-1:0] lp_cnt_q, lp_cnt_d;
`else
  // Long-press sizing has no effect in this build.
  logic unused_lp_cfg;
  assign unused_lp_cfg = (LONG_PRESS_CNT > 0) ^ (LP_W > 0);
`endif

  // Power FSM next state, reset-button pulses and ForceOff level.
  always_comb begin
    pwr_state_d = pwr_state_q;
    force_off_d = force_off_q;
    int_d       = '0;
`ifdef BUTTON_LONG_PRESS_EN
    lp_cnt_d    = lp_cnt_q;
`endif
    int_d[INT_RST_PRS] = rst_rise;
    int_d[INT_RST_REL] = rst_fall;
    case (pwr_state_q)
      IDLE: begin
        if (pwr_rise) begin
          pwr_state_d        = PRESSED;
          int_d[INT_PWR_PRS] = 1'b1;
`ifdef BUTTON_LONG_PRESS_EN
          lp_cnt_d           = '0;
`endif
        end
      end
      PRESSED: begin
        if (pwr_fall) begin
          pwr_state_d        = IDLE;
          int_d[INT_PWR_REL] = 1'b1;
        end else begin
`ifdef BUTTON_LONG_PRESS_EN
          // Enter LONG on the cycle the counter reaches its last value;
          // it then holds there, so it cannot wrap.
          lp_cnt_d = lp_cnt_q + 1'b1;
          if (lp_cnt_d == LP_W'(LONG_PRESS_CNT - 1)) begin
            pwr_state_d = LONG;
            force_off_d = 1'b1;
          end
`endif
        end
      end
`ifdef BUTTON_LONG_PRESS_EN
      LONG: begin
        if (pwr_fall) begin
          pwr_state_d = IDLE;
          force_off_d = 1'b0;
        end
      end
`endif
      default: begin
        pwr_state_d = IDLE;
        force_off_d = 1'b0;
      end
    endcase
  end

  // Register edge-detect history, pulses, FSM state and ForceOff.
  always_ff @(posedge CLK32768) begin
    if (Reset) begin
      pwr_db_prev_q <= 1'b0;
      rst_db_prev_q <= 1'b0;
      int_q         <= '0;
      pwr_state_q   <= IDLE;
      force_off_q   <= 1'b0;
    end else begin
      pwr_db_prev_q <= pwr_db;
      rst_db_prev_q <= rst_db;
      int_q         <= int_d;
      pwr_state_q   <= pwr_state_d;
      force_off_q   <= force_off_d;
    end
  end

`ifdef BUTTON_LONG_PRESS_EN
  // Long-press counter.
  always_ff @(posedge CLK32768) begin
    if (Reset) lp_cnt_q <= '0;
    else       lp_cnt_q <= lp_cnt_d;
  end
`endif

  assign Interrupt = int_q;
  assign PwrBtnDb  = pwr_db;
  assign RstBtnDb  = rst_db;
`ifdef BUTTON_LONG_PRESS_EN
  assign ForceOff  = force_off_q;
`else
  assign ForceOff  = 1'b0;
`endif

endmodule

// File: tb/tb_button_event_detect.sv
// Directed bench for button_event_detect with SYNC_STAGES=2,
// DEBOUNCE_CNT=4, LONG_PRESS_CNT=16. Expectations cover both builds
// (BUTTON_LONG_PRESS_EN defined or not).
// Observed vector layout: {Interrupt[3:0], PwrBtnDb, RstBtnDb, ForceOff}.
module tb_button_event_detect;
  import odsmr_btn_pkg::*;

  localparam int W = 7;
`ifdef BUTTON_LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic       CLK32768 = 1'b0;
  logic       Reset    = 1'b1;
  logic       PwrBtnN  = 1'b1;
  logic       RstBtnN  = 1'b1;
  logic [3:0] Interrupt;
  logic       PwrBtnDb;
  logic       RstBtnDb;
  logic       ForceOff;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  button_event_detect #(
    .SYNC_STAGES   (2),
    .DEBOUNCE_CNT  (4),
    .DB_W          (3),
    .LONG_PRESS_CNT(16),
    .LP_W          (5)
  ) dut (
    .CLK32768 (CLK32768),
    .Reset    (Reset),
    .PwrBtnN  (PwrBtnN),
    .RstBtnN  (RstBtnN),
    .Interrupt(Interrupt),
    .PwrBtnDb (PwrBtnDb),
    .RstBtnDb (RstBtnDb),
    .ForceOff (ForceOff)
  );

  // Clock and reset.
  always #5 CLK32768 = ~CLK32768;

  function automatic logic [W-1:0] mk(input logic [3:0] iv, input logic p,
                                      input logic r, input logic f);
    return {iv, p, r, f};
  endfunction

  function automatic logic [W-1:0] obs_vec();
    return {Interrupt, PwrBtnDb, RstBtnDb, ForceOff};
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the edge.
  task automatic tick();
    @(posedge CLK32768);
    #1;
  endtask

  // Advance n cycles, comparing each cycle with the next queued value.
  task automatic hold(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL %s expectation queue empty observed=%b", tag, obs_vec());
      end else begin
        check(tag, obs_vec(), exp_q.pop_front());
      end
    end
  endtask

  initial begin
    // Reset values with both buttons released.
    repeat (3) tick();
    check("reset_values", obs_vec(), mk(4'b0000, 1'b0, 1'b0, 1'b0));
    Reset = 1'b0;
    for (int k = 1; k <= 4; k++) exp_q.push_back(mk(4'b0000, 1'b0, 1'b0, 1'b0));
    hold("idle", 4);

    // Reset button: 20 cycles low, then released.
    for (int k = 1; k <= 34; k++)
      exp_q.push_back(mk(k == 7 ? 4'b0010 : (k == 27 ? 4'b0001 : 4'b0000),
                         1'b0, (k >= 6 && k < 26), 1'b0));
    RstBtnN = 1'b0;
    hold("rst_press", 20);
    RstBtnN = 1'b1;
    hold("rst_release", 14);

    // Power glitch of 3 cycles is rejected.
    for (int k = 1; k <= 12; k++) exp_q.push_back(mk(4'b0000, 1'b0, 1'b0, 1'b0));
    PwrBtnN = 1'b0;
    hold("pwr_glitch", 3);
    PwrBtnN = 1'b1;
    hold("pwr_glitch", 9);

    // Short power press, 10 cycles.
    for (int k = 1; k <= 22; k++)
      exp_q.push_back(mk(k == 7 ? 4'b1000 : (k == 17 ? 4'b0100 : 4'b0000),
                         (k >= 6 && k < 16), 1'b0, 1'b0));
    PwrBtnN = 1'b0;
    hold("pwr_short", 10);
    PwrBtnN = 1'b1;
    hold("pwr_short_rel", 12);

    // Long power press, 40 cycles.
    for (int k = 1; k <= 54; k++)
      exp_q.push_back(mk(k == 7 ? 4'b1000 :
                         ((k == 47 && !LONG_EN) ? 4'b0100 : 4'b0000),
                         (k >= 6 && k < 46), 1'b0,
                         (LONG_EN && k >= 22 && k < 47)));
    PwrBtnN = 1'b0;
    hold("pwr_long", 40);
    PwrBtnN = 1'b1;
    hold("pwr_long_rel", 14);

    // Both buttons pressed on the same cycle.
    for (int k = 1; k <= 9; k++)
      exp_q.push_back(mk(k == 7 ? 4'b1010 : 4'b0000, (k >= 6), (k >= 6), 1'b0));
    PwrBtnN = 1'b0;
    RstBtnN = 1'b0;
    hold("both_press", 9);

    // Reset while both are held.
    for (int k = 1; k <= 2; k++) exp_q.push_back(mk(4'b0000, 1'b0, 1'b0, 1'b0));
    Reset = 1'b1;
    hold("mid_reset", 2);
    Reset = 1'b0;

    // Held buttons are re-detected after reset release.
    for (int k = 1; k <= 9; k++)
      exp_q.push_back(mk(k == 7 ? 4'b1010 : 4'b0000, (k >= 6), (k >= 6), 1'b0));
    hold("redetect", 9);

    // Release both on the same cycle.
    for (int k = 1; k <= 10; k++)
      exp_q.push_back(mk(k == 7 ? 4'b0101 : 4'b0000, (k < 6), (k < 6), 1'b0));
    PwrBtnN = 1'b1;
    RstBtnN = 1'b1;
    hold("both_release", 10);

    checks++;
    assert (exp_q.size() == 0)
    else begin
      errors++;
      $error("FAIL leftover_expectations observed=%0d expected=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
